// File: rtl/debug_uart_tx.sv
// debug_uart_tx: snapshots the signed debug-sequence bus and sends it as one ASCII hex line over UART 8N1
//   sys_clk    in  system clock, posedge
//   sys_rst_n  in  asynchronous active-low reset
//   trigger    in  one-cycle request to send one line (ignored while busy)
//   seq_bus    in  SEQ_NUM packed two's complement fields of SEQ_LEN bits
//   tx         out UART serial line, idle high
//   busy       out high from snapshot until the line is fully sent
//   frame_done out one-cycle pulse as the last stop bit ends
//   DEBUG_UART_CHECKSUM_EN: appends '*' and two hex digits of the XOR of all payload bytes before CR LF
module debug_uart_tx #(
  parameter int SEQ_LEN  = 20,
  parameter int SEQ_NUM  = 6,
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       trigger,
  input  logic [SEQ_LEN*SEQ_NUM-1:0] seq_bus,
  output logic                       tx,
  output logic                       busy,
  output logic                       frame_done
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int ND  = SEQ_LEN / 4;
`ifdef DEBUG_UART_CHECKSUM_EN
  localparam int TRL = 5;
`else
  localparam int TRL = 2;
`endif
  localparam int BW = $clog2(CPB);
  localparam int FW = $clog2(SEQ_NUM + 1);
  localparam int CW = $clog2(ND + TRL + 2);
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, DONE} state_t;
  state_t                     state, state_n;
  logic [SEQ_LEN*SEQ_NUM-1:0] snap;
  logic [BW-1:0]              bcnt;
  logic [2:0]                 bidx;
  logic [FW-1:0]              fi;
  logic [CW-1:0]              ci;
  logic [7:0]                 sh, ch, fld_ch, trl_ch;
  logic                       last, bit_end, load, payload, field_end, line_end;
  logic [SEQ_LEN-1:0]         field, mag;
  logic [3:0]                 nib;
`ifdef DEBUG_UART_CHECKSUM_EN
  logic [7:0]                 ck;
`endif
  function automatic logic [7:0] hex(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
  always_comb begin
    field     = SEQ_LEN'(snap >> (int'(fi) * SEQ_LEN));
    mag       = field[SEQ_LEN-1] ? -field : field;
    nib       = 4'(mag >> ((ND - int'(ci)) * 4));
    payload   = fi < FW'(SEQ_NUM);
    field_end = ci == ((fi == FW'(SEQ_NUM - 1)) ? CW'(ND) : CW'(ND + 1));
    line_end  = !payload && ci == CW'(TRL - 1);
    fld_ch    = ci == '0 ? (field[SEQ_LEN-1] ? 8'h2D : 8'h2B) : ci == CW'(ND + 1) ? 8'h20 : hex(nib);
`ifdef DEBUG_UART_CHECKSUM_EN
    trl_ch    = ci == CW'(0) ? 8'h2A : ci == CW'(1) ? hex(ck[7:4]) : ci == CW'(2) ? hex(ck[3:0]) :
                ci == CW'(3) ? 8'h0D : 8'h0A;
`else
    trl_ch    = ci == '0 ? 8'h0D : 8'h0A;
`endif
    ch         = payload ? fld_ch : trl_ch;
    bit_end    = bcnt == BW'(CPB - 1);
    load       = state == LOAD || (state == STOP && bit_end && !last);
    busy       = state != IDLE && state != DONE;
    frame_done = state == DONE;
    tx         = state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;
    state_n    = state;
    case (state)
      IDLE:  state_n = trigger ? LOAD : IDLE;
      LOAD:  state_n = START;
      START: state_n = bit_end ? DATA : START;
      DATA:  state_n = bit_end && bidx == 3'd7 ? STOP : DATA;
      STOP:  state_n = bit_end ? (last ? DONE : START) : STOP;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      snap <= '0;
      bcnt <= '0;
      bidx <= '0;
      fi   <= '0;
      ci   <= '0;
      sh   <= '0;
      last <= 1'b0;
`ifdef DEBUG_UART_CHECKSUM_EN
      ck   <= '0;
`endif
    end else begin
      bcnt <= (state == START || state == DATA || state == STOP) && !bit_end ? bcnt + 1'b1 : '0;
      if (state == IDLE && trigger) begin
        snap <= seq_bus;
        fi   <= '0;
        ci   <= '0;
        last <= 1'b0;
`ifdef DEBUG_UART_CHECKSUM_EN
        ck   <= '0;
`endif
      end
      if (load) begin
        sh   <= ch;
        bidx <= '0;
        last <= line_end;
        fi   <= payload && field_end ? fi + 1'b1 : fi;
        ci   <= payload && field_end ? '0 : ci + 1'b1;
`ifdef DEBUG_UART_CHECKSUM_EN
        ck   <= payload ? ck ^ ch : ck;
`endif
      end
      if (state == DATA && bit_end) begin
        sh   <= sh >> 1;
        bidx <= bidx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_debug_uart_tx.sv
// tb_debug_uart_tx: table-driven line checks plus timing, ignored-trigger and mid-line reset sequences
module tb_debug_uart_tx;
  localparam int SL = 20, SN = 6;
  typedef struct {
    logic [SL*SN-1:0] bus;
    string            pay;
    bit               disturb;
  } vec_t;
  logic             sys_clk = 1'b0, sys_rst_n = 1'b0, trigger = 1'b0;
  logic [SL*SN-1:0] seq_bus = '0;
  logic             tx, busy, frame_done;
  int               cyc = 0, n_chk = 0, n_fail = 0;
  vec_t             vecs[4];
  debug_uart_tx #(.SEQ_LEN(SL), .SEQ_NUM(SN), .CLK_FREQ(1000), .BAUD(100)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .trigger(trigger), .seq_bus(seq_bus),
    .tx(tx), .busy(busy), .frame_done(frame_done)
  );
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic string hexdump(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02h", s[i])};
    return r;
  endfunction
  task automatic chk_s(input string name, input string got, input string exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %s expected %s", name, hexdump(got), hexdump(exp));
    end
  endtask
  function automatic string full_line(input string pay);
    string r = pay;
`ifdef DEBUG_UART_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    for (int i = 0; i < pay.len(); i++) x ^= pay[i];
    r = {r, "*", $sformatf("%02X", x)};
`endif
    return {r, $sformatf("%c%c", 8'h0D, 8'h0A)};
  endfunction
  task automatic recv_byte(output logic [7:0] b, output bit ok);
    int t = 0;
    ok = 1'b0;
    b  = 8'h00;
    while (tx !== 1'b0 && t < 3000) begin
      @(negedge sys_clk);
      t++;
    end
    if (tx !== 1'b0) return;
    repeat (5) @(negedge sys_clk);
    for (int j = 0; j < 8; j++) begin
      repeat (10) @(negedge sys_clk);
      b[j] = tx;
    end
    repeat (10) @(negedge sys_clk);
    ok = tx === 1'b1;
  endtask
  task automatic recv_line(output string s, output bit ok);
    logic [7:0] b;
    bit         bok;
    s  = "";
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      recv_byte(b, bok);
      if (!bok) return;
      s = {s, $sformatf("%c", b)};
      if (b == 8'h0A) begin
        ok = 1'b1;
        return;
      end
    end
  endtask
  task automatic run_line(input int i);
    string got, exp;
    bit    ok, dbusy, dseen;
    int    tset, fcyc, dcyc, t;
    exp     = full_line(vecs[i].pay);
    seq_bus = vecs[i].bus;
    @(negedge sys_clk);
    trigger = 1'b1;
    tset    = cyc;
    @(negedge sys_clk);
    trigger = 1'b0;
    chk($sformatf("v%0d busy after snapshot", i), busy, 1);
    chk($sformatf("v%0d tx high in load", i), tx, 1);
    fork
      recv_line(got, ok);
      begin
        t = 0;
        while (tx !== 1'b0 && t < 20) begin
          @(negedge sys_clk);
          t++;
        end
        fcyc = cyc;
        t    = 0;
        while (frame_done !== 1'b1 && t < 10000) begin
          @(negedge sys_clk);
          t++;
        end
        dcyc    = cyc;
        dbusy   = busy;
        dseen   = frame_done;
        trigger = 1'b1;
        @(negedge sys_clk);
        trigger = 1'b0;
      end
      begin
        if (vecs[i].disturb) begin
          repeat (1500) @(negedge sys_clk);
          seq_bus = ~seq_bus;
          trigger = 1'b1;
          @(negedge sys_clk);
          trigger = 1'b0;
        end
      end
    join
    chk($sformatf("v%0d line received", i), ok, 1);
    chk_s($sformatf("v%0d line content", i), got, exp);
    chk($sformatf("v%0d line length", i), got.len(), exp.len());
    chk($sformatf("v%0d start latency", i), fcyc - tset, 2);
    chk($sformatf("v%0d frame_done seen", i), dseen, 1);
    chk($sformatf("v%0d frame duration", i), dcyc - fcyc, 100 * exp.len());
    chk($sformatf("v%0d busy low at frame_done", i), dbusy, 0);
    repeat (3) @(negedge sys_clk);
    chk($sformatf("v%0d trigger in done ignored busy", i), busy, 0);
    chk($sformatf("v%0d trigger in done ignored tx", i), tx, 1);
  endtask
  initial begin
    vecs[0].bus = {20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00005};
    vecs[0].pay = "+00005 +00000 +00000 +00000 +00000 +00000";
    vecs[0].disturb = 1'b0;
    vecs[1].bus = {20'h7FFFF, 20'h12345, 20'h0A3C1, 20'h80000, 20'hFFFFF, 20'h00000};
    vecs[1].pay = "+00000 -00001 -80000 +0A3C1 +12345 +7FFFF";
    vecs[1].disturb = 1'b1;
    vecs[2].bus = {20'h80001, 20'h00000, 20'hFEDCB, 20'h00001, 20'hABCDE, 20'hFFFF0};
    vecs[2].pay = "-00010 -54322 +00001 -01235 +00000 -7FFFF";
    vecs[2].disturb = 1'b0;
    vecs[3].bus = '0;
    vecs[3].pay = "+00000 +00000 +00000 +00000 +00000 +00000";
    vecs[3].disturb = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("reset tx", tx, 1);
    chk("reset busy", busy, 0);
    chk("reset frame_done", frame_done, 0);
    sys_rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    chk("idle tx", tx, 1);
    chk("idle busy", busy, 0);
    chk("idle frame_done", frame_done, 0);
    for (int i = 0; i < 4; i++) run_line(i);
    seq_bus = vecs[2].bus;
    @(negedge sys_clk);
    trigger = 1'b1;
    @(negedge sys_clk);
    trigger = 1'b0;
    for (int t = 0; t < 20 && tx !== 1'b0; t++) @(negedge sys_clk);
    repeat (1030) @(negedge sys_clk);
    chk("busy before mid-line reset", busy, 1);
    chk("tx data bit before mid-line reset", tx, 0);
    sys_rst_n = 1'b0;
    #1;
    chk("async reset tx", tx, 1);
    chk("async reset busy", busy, 0);
    chk("async reset frame_done", frame_done, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("after reset release tx", tx, 1);
    chk("after reset release busy", busy, 0);
    run_line(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
